// File: rtl/hasty_trap_seq_pkg.sv
// Shared types and defaults for the trap-capture sequencer: state enum, cycle constants
// and the index-width helper.
package hasty_trap_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_FLUSH  = 2'd3
    } seq_state_e;

    localparam int DEF_N_TRAPS    = 8;
    localparam int DEF_LOAD_CYC   = 64;
    localparam int DEF_SETTLE_CYC = 16;
    localparam int DEF_FLUSH_CYC  = 32;
    localparam int DEF_WDOG_CYC   = 256;
    localparam int DEF_CNT_W      = 16;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hasty_trap_sequencer_rr_arbiter.sv
// Combinational N-way round-robin pick: first set request at or after ptr_i, wrapping.
module rr_arbiter
    import hasty_trap_seq_pkg::*;
#(
    parameter int N  = DEF_N_TRAPS,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    logic [IW-1:0] cand;

    // N is a power of two, so IW-bit wraparound of ptr+i is the modulo.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int i = 0; i < N; i++) begin
            cand = ptr_i + IW'(i);
            if (!valid_o && req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
        if (valid_o) begin
            gnt_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/hasty_trap_sequencer.sv
// Round-robin LOAD/SETTLE/FLUSH sequencer for the eight-trap inlet tree.
// HASTY_TRAP_SEQ_WDOG_EN adds the LOAD pressure watchdog and sticky fault.
module hasty_trap_sequencer
    import hasty_trap_seq_pkg::*;
#(
    parameter int N_TRAPS    = DEF_N_TRAPS,
    parameter int LOAD_CYC   = DEF_LOAD_CYC,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int FLUSH_CYC  = DEF_FLUSH_CYC,
    parameter int CNT_W      = DEF_CNT_W
`ifdef HASTY_TRAP_SEQ_WDOG_EN
    ,
    parameter int WDOG_CYC   = DEF_WDOG_CYC
`endif
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [N_TRAPS-1:0] req_i,
    input  logic               press_ok_i,
    output logic [N_TRAPS-1:0] valve_o,
    output logic               pump_o,
    output logic               flush_valve_o,
    output logic               busy_o,
    output logic [N_TRAPS-1:0] done_o,
    output logic               fault_o
);

    localparam int IW = idx_w(N_TRAPS);
    localparam logic [CNT_W-1:0] LOAD_RLD   = CNT_W'(LOAD_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_RLD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] FLUSH_RLD  = CNT_W'(FLUSH_CYC - 1);

    seq_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]      g_q, g_d, ptr_q, ptr_d;
    logic [N_TRAPS-1:0] gnt_q, gnt_d;
    logic               fault_q, fault_d;
    logic [N_TRAPS-1:0] valve_q, valve_d, done_q, done_d;
    logic               pump_q, pump_d, flush_q, flush_d, busy_q, busy_d;

    logic [N_TRAPS-1:0] arb_gnt;
    logic [IW-1:0]      arb_idx;
    logic               arb_valid;

`ifdef HASTY_TRAP_SEQ_WDOG_EN
    localparam logic [CNT_W-1:0] WDOG_RLD = CNT_W'(WDOG_CYC - 1);
    logic [CNT_W-1:0] wd_q, wd_d;
`endif

    rr_arbiter #(.N(N_TRAPS), .IW(IW)) u_arb (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        g_d     = g_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        fault_d = fault_q;
`ifdef HASTY_TRAP_SEQ_WDOG_EN
        wd_d    = wd_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (arb_valid && !fault_q) begin
                    state_d = ST_LOAD;
                    cnt_d   = LOAD_RLD;
                    g_d     = arb_idx;
                    gnt_d   = arb_gnt;
`ifdef HASTY_TRAP_SEQ_WDOG_EN
                    wd_d    = '0;
`endif
                end
            end
            ST_LOAD: begin
                if (press_ok_i) begin
`ifdef HASTY_TRAP_SEQ_WDOG_EN
                    wd_d = '0;
`endif
                    if (cnt_q == '0) begin
                        state_d = ST_SETTLE;
                        cnt_d   = SETTLE_RLD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
`ifdef HASTY_TRAP_SEQ_WDOG_EN
                // wd_q == WDOG_CYC-1 means this low cycle is the WDOG_CYC-th in a row.
                else if (wd_q == WDOG_RLD) begin
                    fault_d = 1'b1;
                    state_d = ST_FLUSH;
                    cnt_d   = FLUSH_RLD;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_FLUSH;
                    cnt_d   = FLUSH_RLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    ptr_d   = g_q + 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        valve_d = (state_d == ST_LOAD || state_d == ST_SETTLE) ? gnt_d : '0;
        pump_d  = (state_d == ST_LOAD);
        flush_d = (state_d == ST_FLUSH);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_FLUSH && cnt_d == '0 && !fault_d) ? gnt_d : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            g_q     <= '0;
            gnt_q   <= '0;
            ptr_q   <= '0;
            valve_q <= '0;
            pump_q  <= 1'b0;
            flush_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            g_q     <= g_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            valve_q <= valve_d;
            pump_q  <= pump_d;
            flush_q <= flush_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef HASTY_TRAP_SEQ_WDOG_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wd_q    <= '0;
            fault_q <= 1'b0;
        end else begin
            wd_q    <= wd_d;
            fault_q <= fault_d;
        end
    end
`else
    assign fault_q = 1'b0;
`endif

    assign valve_o       = valve_q;
    assign pump_o        = pump_q;
    assign flush_valve_o = flush_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign fault_o       = fault_q;

endmodule

// File: tb/tb_hasty_trap_sequencer.sv
// Self-checking bench for hasty_trap_sequencer: directed scenarios plus random traffic
// against a phase/elapsed-count reference model. Honours HASTY_TRAP_SEQ_WDOG_EN.
module tb_hasty_trap_sequencer;

    localparam int N  = 8;
    localparam int LC = 4;
    localparam int SC = 2;
    localparam int FC = 3;
    localparam int WC = 8;
`ifdef HASTY_TRAP_SEQ_WDOG_EN
    localparam int STALL = 7;
`else
    localparam int STALL = 10;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         press;
    logic [N-1:0] req;
    logic [N-1:0] valve, done;
    logic         pump, flush_v, busy, fault;

    always #5 clk = ~clk;

    hasty_trap_sequencer #(
        .N_TRAPS    (N),
        .LOAD_CYC   (LC),
        .SETTLE_CYC (SC),
        .FLUSH_CYC  (FC),
        .CNT_W      (8)
`ifdef HASTY_TRAP_SEQ_WDOG_EN
        ,
        .WDOG_CYC   (WC)
`endif
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_i         (req),
        .press_ok_i    (press),
        .valve_o       (valve),
        .pump_o        (pump),
        .flush_valve_o (flush_v),
        .busy_o        (busy),
        .done_o        (done),
        .fault_o       (fault)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: phase 0 idle, 1 load, 2 settle, 3 flush; progress counted upward.
    int m_phase = 0, m_g = 0, m_ptr = 0, m_ld = 0, m_el = 0, m_low = 0;
    bit m_fault = 1'b0;

    int n_valve, n_pump, n_flush, n_settle, n_done, n_busy;
    int grants[$];
    bit prev_busy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_step(input bit r_rst, input logic [N-1:0] r_req, input bit r_press);
        if (r_rst) begin
            m_phase = 0; m_ptr = 0; m_fault = 1'b0;
            return;
        end
        case (m_phase)
            0: if (r_req != 0 && !m_fault) begin
                m_g = pick(r_req, m_ptr); m_phase = 1; m_ld = 0; m_low = 0;
            end
            1: if (r_press) begin
                m_ld++; m_low = 0;
                if (m_ld == LC) begin m_phase = 2; m_el = 0; end
            end else begin
`ifdef HASTY_TRAP_SEQ_WDOG_EN
                m_low++;
                if (m_low == WC) begin m_fault = 1'b1; m_phase = 3; m_el = 0; end
`endif
            end
            2: begin
                m_el++;
                if (m_el == SC) begin m_phase = 3; m_el = 0; end
            end
            default: begin
                m_el++;
                if (m_el == FC) begin m_phase = 0; m_ptr = (m_g + 1) % N; end
            end
        endcase
    endtask

    task automatic reset_meas();
        n_valve = 0; n_pump = 0; n_flush = 0; n_settle = 0; n_done = 0; n_busy = 0;
        grants.delete();
    endtask

    task automatic tick(input bit r_rst, input logic [N-1:0] r_req, input bit r_press);
        logic [N-1:0] ev, ed;
        rst = r_rst; req = r_req; press = r_press;
        @(posedge clk);
        model_step(r_rst, r_req, r_press);
        #1;
        ev = (m_phase == 1 || m_phase == 2) ? N'(1) << m_g : '0;
        ed = (m_phase == 3 && m_el == FC - 1 && !m_fault) ? N'(1) << m_g : '0;
        chk("valve", 32'(valve), 32'(ev));
        chk("pump", 32'(pump), 32'(m_phase == 1));
        chk("flush_valve", 32'(flush_v), 32'(m_phase == 3));
        chk("busy", 32'(busy), 32'(m_phase != 0));
        chk("done", 32'(done), 32'(ed));
        chk("fault", 32'(fault), 32'(m_fault));
        if (valve != 0) n_valve++;
        if (pump) n_pump++;
        if (flush_v) n_flush++;
        if (valve != 0 && !pump) n_settle++;
        if (done != 0) n_done++;
        if (busy) n_busy++;
        if (busy && !prev_busy) grants.push_back(oh_idx(valve));
        prev_busy = busy;
    endtask

    initial begin
        rst = 1'b1; req = '0; press = 1'b1;
        tick(1, 0, 1);
        tick(1, 0, 1);

        // Single request pulse
        reset_meas();
        tick(0, 8'h01, 1);
        repeat (11) tick(0, 8'h00, 1);
        chk("single_valve_cycles", 32'(n_valve), 32'(LC + SC));
        chk("single_pump_cycles", 32'(n_pump), 32'(LC));
        chk("single_flush_cycles", 32'(n_flush), 32'(FC));
        chk("single_done_pulses", 32'(n_done), 32'd1);
        chk("single_busy_cycles", 32'(n_busy), 32'(LC + SC + FC));

        // Round-robin with all requests held
        tick(1, 0, 1);
        reset_meas();
        repeat (82) tick(0, 8'hFF, 1);
        chk("rr_grant_count", 32'(grants.size()), 32'd9);
        for (int i = 0; i < 9; i++) begin
            chk("rr_grant_order", 32'((grants.size() > i) ? grants[i] : -1), 32'(i % N));
        end

        // Pointer at 5 with requests 5 and 0
        tick(1, 0, 1);
        tick(0, 8'h10, 1);
        repeat (10) tick(0, 8'h00, 1);
        reset_meas();
        repeat (20) tick(0, 8'h21, 1);
        chk("ptr5_first", 32'((grants.size() > 0) ? grants[0] : -1), 32'd5);
        chk("ptr5_second", 32'((grants.size() > 1) ? grants[1] : -1), 32'd0);

        // Pressure stall in the middle of LOAD
        tick(1, 0, 1);
        reset_meas();
        tick(0, 8'h01, 1);
        repeat (2) tick(0, 8'h00, 1);
        repeat (STALL) tick(0, 8'h00, 0);
        repeat (20) tick(0, 8'h00, 1);
        chk("stall_pump_cycles", 32'(n_pump), 32'(LC + STALL));
        chk("stall_settle_cycles", 32'(n_settle), 32'(SC));
        chk("stall_flush_cycles", 32'(n_flush), 32'(FC));
        chk("stall_done_pulses", 32'(n_done), 32'd1);

        // Reset while in SETTLE
        tick(1, 0, 1);
        reset_meas();
        tick(0, 8'h04, 1);
        repeat (4) tick(0, 8'h00, 1);
        chk("pre_rst_in_settle", 32'(valve != 0 && !pump), 32'd1);
        tick(1, 8'h00, 1);
        chk("rst_settle_busy", 32'(busy), 32'd0);
        chk("rst_settle_valve", 32'(valve), 32'd0);
        repeat (3) tick(0, 8'h00, 1);
        chk("rst_settle_no_done", 32'(n_done), 32'd0);
        grants.delete();
        tick(0, 8'hFF, 1);
        chk("rst_settle_next_grant", 32'((grants.size() > 0) ? grants[0] : -1), 32'd0);
        repeat (10) tick(0, 8'h00, 1);

        // Pressure never good in LOAD
        tick(1, 0, 1);
        reset_meas();
        tick(0, 8'h01, 0);
        repeat (12) tick(0, 8'h00, 0);
`ifdef HASTY_TRAP_SEQ_WDOG_EN
        chk("wdog_fault", 32'(fault), 32'd1);
        chk("wdog_flush_cycles", 32'(n_flush), 32'(FC));
        chk("wdog_no_done", 32'(n_done), 32'd0);
        repeat (5) tick(0, 8'hFF, 1);
        chk("wdog_blocks_grants", 32'(busy), 32'd0);
`else
        chk("nowdog_stays_load", 32'(pump), 32'd1);
        chk("nowdog_fault", 32'(fault), 32'd0);
        repeat (12) tick(0, 8'h00, 1);
        chk("nowdog_done", 32'(n_done), 32'd1);
`endif

        // Random traffic
        tick(1, 0, 1);
        for (int i = 0; i < 1500; i++) begin
            tick(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 3) == 0) ? N'($urandom) : N'(0),
                 ($urandom_range(0, 9) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
